// File: rtl/minrv32_mem_responder.sv
// minrv32_mem_responder: wait-state RAM slave for the minrv32 native memory bus
// with range checking, access counters and a sticky bus-error record.
module minrv32_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        bus_err,
   output logic        err_sticky,
   output logic [31:0] err_addr,
   output logic [31:0] fetch_count,
   output logic [31:0] load_count,
   output logic [31:0] store_count
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state;
   logic [31:0] ram [DEPTH_WORDS];
   logic [31:0] addr_q, wdata_q, c_addr, c_wdata;
   logic [3:0] wstrb_q, c_wstrb, cnt;
   logic instr_q, c_instr, in_range, go_resp;
   logic [AW-1:0] wi;
   // In IDLE the live bus is used so a zero-wait access completes on the accepting edge.
   always_comb begin
      c_addr = state == IDLE ? mem_addr : addr_q;
      c_wdata = state == IDLE ? mem_wdata : wdata_q;
      c_wstrb = state == IDLE ? mem_wstrb : wstrb_q;
      c_instr = state == IDLE ? mem_instr : instr_q;
      in_range = {1'b0, c_addr} >= {1'b0, BASE_ADDR} && {1'b0, c_addr} < LIMIT;
      wi = AW'((c_addr - BASE_ADDR) >> 2);
      go_resp = mem_valid && (state == IDLE ? WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd0);
   end
   always_ff @(posedge clk)
      if (go_resp && !reset && in_range)
         for (int b = 0; b < 4; b++)
            if (c_wstrb[b]) ram[wi][8*b +: 8] <= c_wdata[8*b +: 8];
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         bus_err <= 1'b0;
         err_sticky <= 1'b0;
         err_addr <= '0;
         fetch_count <= '0;
         load_count <= '0;
         store_count <= '0;
         cnt <= '0;
      end else begin
         mem_ready <= go_resp;
         bus_err <= go_resp && !in_range;
         if (go_resp) begin
            mem_rdata <= |c_wstrb ? '0 : in_range ? ram[wi] : ERR_RDATA;
            if (|c_wstrb) store_count <= store_count + 32'd1;
            else if (c_instr) fetch_count <= fetch_count + 32'd1;
            else load_count <= load_count + 32'd1;
            if (!in_range) begin
               err_sticky <= 1'b1;
               if (!err_sticky) err_addr <= c_addr;
            end
         end
         case (state)
            IDLE: if (mem_valid) begin
               addr_q <= mem_addr;
               wdata_q <= mem_wdata;
               wstrb_q <= mem_wstrb;
               instr_q <= mem_instr;
               cnt <= 4'(WAIT_CYCLES - 1);
               state <= WAIT_CYCLES == 0 ? RESP : WAIT;
            end
            WAIT: if (!mem_valid) begin
               state <= IDLE;
               err_sticky <= 1'b1;
               if (!err_sticky) err_addr <= addr_q;
            end else if (cnt == 4'd0) state <= RESP;
            else cnt <= cnt - 4'd1;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_minrv32_mem_responder.sv
// tb_minrv32_mem_responder: three responders (0, 2 and 3 wait states) checked
// against a word-array reference model, with directed tables and random traffic.
module tb_minrv32_mem_responder;
   localparam logic [31:0] BASE = 32'h0001_0000;
   localparam int DEPTH = 1024;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst [3], valid [3], instr [3], ready [3], berr [3], sticky [3];
   logic [31:0] addr [3], wdata [3], rdata [3], eaddr [3], fc [3], lc [3], sc [3];
   logic [3:0] wstrb [3];
   for (genvar k = 0; k < 3; k++) begin : g
      minrv32_mem_responder #(.WAIT_CYCLES(k == 0 ? 0 : k == 1 ? 2 : 3)) dut (
         .clk(clk), .reset(rst[k]), .mem_valid(valid[k]), .mem_instr(instr[k]),
         .mem_addr(addr[k]), .mem_wdata(wdata[k]), .mem_wstrb(wstrb[k]),
         .mem_ready(ready[k]), .mem_rdata(rdata[k]), .bus_err(berr[k]),
         .err_sticky(sticky[k]), .err_addr(eaddr[k]), .fetch_count(fc[k]),
         .load_count(lc[k]), .store_count(sc[k]));
   end
   logic [31:0] m_mem [3][DEPTH];
   logic [31:0] m_fc [3], m_lc [3], m_sc [3], m_eaddr [3];
   logic m_sticky [3];
   int n_cmp = 0, n_err = 0;
   typedef struct {logic [31:0] a, d; logic [3:0] s; logic i; logic [31:0] er; logic eb;} vec_t;
   vec_t tbl [10];
   function automatic int wc(input int k);
      return k == 0 ? 0 : k == 1 ? 2 : 3;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   task automatic chk_state(input int k);
      chk("fetch_count", fc[k], m_fc[k]);
      chk("load_count", lc[k], m_lc[k]);
      chk("store_count", sc[k], m_sc[k]);
      chk("err_sticky", 32'(sticky[k]), 32'(m_sticky[k]));
      chk("err_addr", eaddr[k], m_eaddr[k]);
   endtask
   task automatic model_reset(input int k);
      m_fc[k] = 0; m_lc[k] = 0; m_sc[k] = 0; m_sticky[k] = 0; m_eaddr[k] = 0;
   endtask
   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic i, output logic [31:0] rd, output logic be);
      int lat, w;
      bit ok;
      logic [31:0] exp;
      ok = longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 4 * DEPTH;
      w = ok ? int'((a - BASE) >> 2) : 0;
      exp = s != 0 ? 32'h0 : ok ? m_mem[k][w] : ERR;
      if (ok) for (int b = 0; b < 4; b++) if (s[b]) m_mem[k][w][8*b +: 8] = d[8*b +: 8];
      if (s != 0) m_sc[k]++;
      else if (i) m_fc[k]++;
      else m_lc[k]++;
      if (!ok) begin
         if (!m_sticky[k]) m_eaddr[k] = a;
         m_sticky[k] = 1;
      end
      valid[k] = 1; addr[k] = a; wdata[k] = d; wstrb[k] = s; instr[k] = i;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (ready[k] !== 1'b1 && lat < 20);
      chk("latency", lat, wc(k) + 1);
      rd = rdata[k];
      be = berr[k];
      chk("rdata", rd, exp);
      chk("bus_err", 32'(be), 32'(!ok));
      @(negedge clk);
      chk("ready_pulse", 32'(ready[k]), 0);
      valid[k] = 0;
      wstrb[k] = 0;
      chk_state(k);
   endtask
   initial begin
      logic [31:0] rd, a;
      logic be;
      logic [3:0] s;
      tbl[0] = '{32'h0001_0000, 32'h1234_5678, 4'hF, 1'b0, 32'h0, 1'b0};
      tbl[1] = '{32'h0001_0000, 32'h0, 4'h0, 1'b0, 32'h1234_5678, 1'b0};
      tbl[2] = '{32'h0001_0004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b0};
      tbl[3] = '{32'h0001_0004, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0, 1'b0};
      tbl[4] = '{32'h0001_0004, 32'h0, 4'h0, 1'b0, 32'hFFBB_FFDD, 1'b0};
      tbl[5] = '{32'h0000_FFFC, 32'h0, 4'h0, 1'b0, ERR, 1'b1};
      tbl[6] = '{32'h0001_1000, 32'h5555_5555, 4'hF, 1'b0, 32'h0, 1'b1};
      tbl[7] = '{32'h0001_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0};
      tbl[8] = '{32'h0001_0FFE, 32'h0, 4'h0, 1'b0, 32'hCAFE_F00D, 1'b0};
      tbl[9] = '{32'hFFFF_FFFC, 32'h0, 4'h0, 1'b1, ERR, 1'b1};
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1; valid[k] = 0; instr[k] = 0; addr[k] = 0; wdata[k] = 0; wstrb[k] = 0;
         model_reset(k);
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(ready[k]), 0);
         chk("rst_rdata", rdata[k], 0);
         chk("rst_bus_err", 32'(berr[k]), 0);
         chk_state(k);
      end
      for (int k = 0; k < 3; k++) rst[k] = 0;
      // Request presented in the same cycle reset drops.
      txn(2, 32'h0001_0008, 32'h0000_0013, 4'hF, 1'b0, rd, be);
      txn(2, 32'h0001_0008, 32'h0, 4'h0, 1'b1, rd, be);
      chk("fetch_one", fc[2], 1);
      for (int j = 0; j < 10; j++) begin
         txn(0, tbl[j].a, tbl[j].d, tbl[j].s, tbl[j].i, rd, be);
         chk("tbl_rdata", rd, tbl[j].er);
         chk("tbl_bus_err", 32'(be), 32'(tbl[j].eb));
      end
      txn(0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, rd, be);
      chk("oob_write_no_alias", rd, 32'h1234_5678);
      chk("first_err_addr", eaddr[0], 32'h0000_FFFC);
      // Protocol abort: drop mem_valid while waiting.
      txn(1, 32'h0001_0010, 32'h1111_1111, 4'hF, 1'b0, rd, be);
      valid[1] = 1; addr[1] = 32'h0001_0010; wdata[1] = 32'h2222_2222; wstrb[1] = 4'hF; instr[1] = 0;
      @(negedge clk);
      valid[1] = 0;
      wstrb[1] = 0;
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_ready", 32'(ready[1]), 0);
      end
      m_sticky[1] = 1;
      m_eaddr[1] = 32'h0001_0010;
      chk_state(1);
      txn(1, 32'h0001_0010, 32'h0, 4'h0, 1'b0, rd, be);
      chk("abort_no_write", rd, 32'h1111_1111);
      // Reset during the wait of a write.
      valid[2] = 1; addr[2] = 32'h0001_0008; wdata[2] = 32'h9999_9999; wstrb[2] = 4'hF; instr[2] = 0;
      @(negedge clk);
      rst[2] = 1;
      @(negedge clk);
      rst[2] = 0;
      valid[2] = 0;
      wstrb[2] = 0;
      model_reset(2);
      chk_state(2);
      repeat (5) begin
         @(negedge clk);
         chk("rst_mid_no_ready", 32'(ready[2]), 0);
      end
      txn(2, 32'h0001_0008, 32'h0, 4'h0, 1'b0, rd, be);
      chk("rst_mid_dropped_write", rd, 32'h0000_0013);
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 16; j++) txn(k, BASE + 32'(4 * j), $urandom, 4'hF, 1'b0, rd, be);
         for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 4) == 0)
               case ($urandom_range(0, 3))
                  0: a = BASE - 32'd4;
                  1: a = BASE + 32'(4 * DEPTH);
                  2: a = 32'hFFFF_FFFC;
                  default: a = $urandom_range(0, 32'h0000_FFFC);
               endcase
            else a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            s = $urandom_range(0, 1) == 1 ? 4'($urandom) : 4'h0;
            txn(k, a, $urandom, s, 1'($urandom), rd, be);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/minrv32_mem_responder.md
# minrv32_mem_responder

Single-port memory responder that terminates the minrv32 native memory bus (mem_valid/mem_ready handshake, byte write strobes) on the slave side. It holds a word-addressed RAM at a fixed base address, inserts a configurable number of wait states, and answers every request, including out-of-range ones, so the core never hangs. It sits next to the core in simulation and FPGA builds and provides access counters plus a sticky bus-error record for debug.

## Interface
- BASE_ADDR, 32'h0001_0000: byte address of word 0; matches the core reset PC.
- DEPTH_WORDS, 1024: RAM depth in 32-bit words; power of two, ≥2.
- WAIT_CYCLES, 0: extra cycles between acceptance and mem_ready; 0..15.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned for out-of-range reads.

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  request pending; held with address and data stable until mem_ready
- mem_instr  in  1  request is an instruction fetch; counting only
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 4'b0000 = read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- bus_err  out  1  pulses with mem_ready when the access was out of range
- err_sticky  out  1  set by any out-of-range access or by protocol abort; cleared only by reset
- err_addr  out  32  mem_addr of the first error event since reset
- fetch_count, load_count, store_count  out  32 each  completed fetches, data reads, writes; wrap mod 2^32

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE with mem_valid=1: latch the request (addr, wdata, wstrb, instr, in_range). Go to WAIT with wait counter = WAIT_CYCLES, or go straight to RESP when WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle; at 0, go to RESP.
- On the edge entering RESP:
  - In-range write: commit bytes whose wstrb bit is set. Other bytes are unchanged.
  - In-range read: mem_rdata = RAM[word].
  - Out-of-range read: mem_rdata = ERR_RDATA.
  - Writes: mem_rdata = 0.
  - The matching counter increments; out-of-range accesses are counted too.
- RESP: mem_ready=1 and bus_err=in_range?0:1 for exactly one cycle, then IDLE unconditionally. mem_valid during RESP is not a new request.
- In range means BASE_ADDR ≤ mem_addr < BASE_ADDR+4*DEPTH_WORDS. Compare as unsigned 33-bit to avoid wrap at 2^32. Word index = (mem_addr−BASE_ADDR)[log2(DEPTH)+1:2].
- Out-of-range writes never modify RAM.
- Protocol abort: mem_valid=0 in WAIT returns to IDLE with no write, no ready, no count increment. It sets err_sticky and records err_addr (if first error).
- Counter classification:
  - wstrb≠0 is a store, regardless of mem_instr.
  - wstrb=0 with mem_instr=1 is a fetch.
  - Everything else is a load.

## Timing
- Reset values: state IDLE, mem_ready 0, mem_rdata 0, bus_err 0, err_sticky 0, err_addr 0, all counters 0. RAM contents are not affected by reset.
- Latency: request accepted in cycle t (IDLE, mem_valid=1) gives mem_ready=1 in cycle t+1+WAIT_CYCLES.
- Back-to-back throughput: one transaction per 2+WAIT_CYCLES cycles. The cycle after RESP can accept the next request.
- mem_rdata holds its value outside RESP until the next RESP; only the RESP cycle is significant.
- Write data is visible to a read accepted in the cycle after the write's RESP.
- Reset mid-transaction (WAIT or RESP): next cycle IDLE, mem_ready 0. A write not yet committed is dropped.
- Counters increment on the edge entering RESP. Wrap from 32'hFFFF_FFFF to 0.
- mem_valid asserted in the same cycle reset is released: accepted on the first non-reset edge.

## Test plan
- WAIT_CYCLES=0, write 32'h1234_5678 to 0x10000 with wstrb=4'hF, then read 0x10000 → mem_ready in cycle t+1 each time; read returns 32'h1234_5678; store_count=1, load_count=1.
- Byte-strobe merge: write 32'hFFFF_FFFF to 0x10004, then 32'hAABB_CCDD with wstrb=4'b0101 → readback 32'hFFBB_FFDD.
- WAIT_CYCLES=3, fetch of 0x10008 with mem_instr=1 → mem_ready exactly 4 cycles after acceptance and high for 1 cycle; fetch_count=1.
- Out of range:
  - read 0x0000_FFFC → ERR_RDATA, bus_err=1, err_sticky=1, err_addr=0x0000_FFFC;
  - write to 0x10000+4*DEPTH_WORDS → RAM unchanged, err_addr still 0x0000_FFFC.
- WAIT_CYCLES=2, drop mem_valid in WAIT → no mem_ready, no write, counters unchanged, err_sticky=1; the next request completes normally.
- Assert reset during WAIT of a write → returns to IDLE, mem_ready stays 0, target word keeps its old value; counters and err_sticky read 0.
